// File: rtl/regfile_wb_scheduler_if.sv
// Handshake bundle between decode/execute/memory stages, the writeback scheduler and the register file.
interface regfile_wb_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rs;
  logic [ADDR_WIDTH-1:0] issue_rt;
  logic [ADDR_WIDTH-1:0] issue_dest;
  logic                  issue_ready;

  logic                  alu_wb_valid;
  logic [ADDR_WIDTH-1:0] alu_wb_reg;
  logic [DATA_WIDTH-1:0] alu_wb_data;
  logic                  alu_wb_ready;

  logic                  mem_wb_valid;
  logic [ADDR_WIDTH-1:0] mem_wb_reg;
  logic [DATA_WIDTH-1:0] mem_wb_data;
  logic                  mem_wb_ready;

  logic                  rf_write_enable;
  logic [ADDR_WIDTH-1:0] rf_write_reg;
  logic [DATA_WIDTH-1:0] rf_busW;
  logic                  wb_err;

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_dest,
    output issue_ready,
    input  alu_wb_valid, alu_wb_reg, alu_wb_data,
    output alu_wb_ready,
    input  mem_wb_valid, mem_wb_reg, mem_wb_data,
    output mem_wb_ready,
    output rf_write_enable, rf_write_reg, rf_busW, wb_err
  );

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_dest,
    input  issue_ready,
    output alu_wb_valid, alu_wb_reg, alu_wb_data,
    input  alu_wb_ready,
    output mem_wb_valid, mem_wb_reg, mem_wb_data,
    input  mem_wb_ready,
    input  rf_write_enable, rf_write_reg, rf_busW, wb_err
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU/MEM writebacks onto the single register-file write port and tracks pending writes.
// Optional macro WB_ROUND_ROBIN_EN: round-robin on conflicts instead of fixed MEM-over-ALU priority.
module regfile_wb_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                   clk,
  input logic                   rst,
  regfile_wb_scheduler_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_next;
  logic                  alu_grant;
  logic                  mem_grant;
  logic                  any_grant;
  logic                  conflict;
  logic                  issue_fire;
  logic [ADDR_WIDTH-1:0] grant_reg;
  logic [DATA_WIDTH-1:0] grant_data;

  assign bus.issue_ready = !pending[bus.issue_rs] && !pending[bus.issue_rt] && !pending[bus.issue_dest];
  assign issue_fire      = bus.issue_valid && bus.issue_ready;
  assign conflict        = bus.alu_wb_valid && bus.mem_wb_valid;

`ifdef WB_ROUND_ROBIN_EN
  typedef enum logic {LAST_ALU, LAST_MEM} last_t;
  last_t last_grant;

  always_comb begin
    alu_grant = bus.alu_wb_valid;
    mem_grant = bus.mem_wb_valid;
    if (conflict) begin
      alu_grant = (last_grant == LAST_MEM);
      mem_grant = (last_grant == LAST_ALU);
    end
  end

  // Pointer only moves on conflict cycles so a lone requester does not steal the next turn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= LAST_MEM;
    end else if (conflict) begin
      last_grant <= mem_grant ? LAST_MEM : LAST_ALU;
    end
  end
`else
  always_comb begin
    mem_grant = bus.mem_wb_valid;
    alu_grant = bus.alu_wb_valid && !bus.mem_wb_valid;
  end
`endif

  assign any_grant        = alu_grant || mem_grant;
  assign grant_reg        = mem_grant ? bus.mem_wb_reg  : bus.alu_wb_reg;
  assign grant_data       = mem_grant ? bus.mem_wb_data : bus.alu_wb_data;
  assign bus.alu_wb_ready = alu_grant;
  assign bus.mem_wb_ready = mem_grant;

  // Clear follows the register-file commit; a new reservation wins if both hit one register.
  always_comb begin
    pending_next = pending;
    if (bus.rf_write_enable) begin
      pending_next[bus.rf_write_reg] = 1'b0;
    end
    if (issue_fire) begin
      pending_next[bus.issue_dest] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rf_write_enable <= 1'b0;
      bus.rf_write_reg    <= '0;
      bus.rf_busW         <= '0;
      bus.wb_err          <= 1'b0;
    end else begin
      if (any_grant) begin
        bus.rf_write_enable <= (grant_reg != '0);
        bus.rf_write_reg    <= grant_reg;
        bus.rf_busW         <= grant_data;
        if ((grant_reg != '0) && !pending[grant_reg]) begin
          bus.wb_err <= 1'b1;
        end
      end else begin
        bus.rf_write_enable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: reference model of the scoreboard/arbiter plus directed scenarios.
module tb_regfile_wb_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  typedef struct {
    bit [AW-1:0] r;
    bit [DW-1:0] d;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   checking = 1'b0;

  regfile_wb_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_wb_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a reservation per register, the arbitration rule, and the last write shown on the port.
  bit          m_pend [NR];
  bit          m_we;
  bit [AW-1:0] m_reg;
  bit [DW-1:0] m_data;
  bit          m_err;
  bit          m_last_mem;

  wb_t         alu_q [$];
  wb_t         mem_q [$];
  bit [AW-1:0] wr_log [$];

  function automatic bit model_issue_ok();
    return !m_pend[bus.issue_rs] && !m_pend[bus.issue_rt] && !m_pend[bus.issue_dest];
  endfunction

  function automatic bit model_mem_grant();
    if (!bus.mem_wb_valid) return 1'b0;
    if (!bus.alu_wb_valid) return 1'b1;
`ifdef WB_ROUND_ROBIN_EN
    return !m_last_mem;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit model_alu_grant();
    return bus.alu_wb_valid && !model_mem_grant();
  endfunction

  function automatic bit [AW-1:0] model_wb_reg();
    return model_mem_grant() ? bus.mem_wb_reg : bus.alu_wb_reg;
  endfunction

  function automatic bit [DW-1:0] model_wb_data();
    return model_mem_grant() ? bus.mem_wb_data : bus.alu_wb_data;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_pend[i]) m_pend[i] <= 1'b0;
      m_we       <= 1'b0;
      m_reg      <= '0;
      m_data     <= '0;
      m_err      <= 1'b0;
      m_last_mem <= 1'b1;
    end else begin
      if (m_we) m_pend[m_reg] <= 1'b0;
      if (bus.issue_valid && model_issue_ok() && bus.issue_dest != 0) m_pend[bus.issue_dest] <= 1'b1;
      if (model_alu_grant() || model_mem_grant()) begin
        m_we   <= (model_wb_reg() != 0);
        m_reg  <= model_wb_reg();
        m_data <= model_wb_data();
        if (model_wb_reg() != 0 && !m_pend[model_wb_reg()]) m_err <= 1'b1;
      end else begin
        m_we <= 1'b0;
      end
      if (bus.alu_wb_valid && bus.mem_wb_valid) m_last_mem <= model_mem_grant();
    end
  end

  task automatic check_output(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_output("issue_ready", bus.issue_ready, model_issue_ok());
      check_output("alu_wb_ready", bus.alu_wb_ready, model_alu_grant());
      check_output("mem_wb_ready", bus.mem_wb_ready, model_mem_grant());
      check_output("rf_write_enable", bus.rf_write_enable, m_we);
      check_output("rf_write_reg", bus.rf_write_reg, m_reg);
      check_output("rf_busW", bus.rf_busW, m_data);
      check_output("wb_err", bus.wb_err, m_err);
      if (bus.rf_write_enable === 1'b1) wr_log.push_back(bus.rf_write_reg);
    end
  end

  task automatic set_issue(input bit v, input bit [AW-1:0] rs, input bit [AW-1:0] rt, input bit [AW-1:0] dest);
    bus.issue_valid = v;
    bus.issue_rs    = rs;
    bus.issue_rt    = rt;
    bus.issue_dest  = dest;
  endtask

  task automatic set_alu(input bit v, input bit [AW-1:0] r, input bit [DW-1:0] d);
    bus.alu_wb_valid = v;
    bus.alu_wb_reg   = r;
    bus.alu_wb_data  = d;
  endtask

  task automatic set_mem(input bit v, input bit [AW-1:0] r, input bit [DW-1:0] d);
    bus.mem_wb_valid = v;
    bus.mem_wb_reg   = r;
    bus.mem_wb_data  = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  // Requesters present their queue heads and hold them until the scheduler accepts.
  task automatic apply_stimulus();
    int budget = 40;
    while ((alu_q.size() != 0 || mem_q.size() != 0) && budget > 0) begin
      bit a_acc;
      bit m_acc;
      if (alu_q.size() != 0) set_alu(1'b1, alu_q[0].r, alu_q[0].d);
      else set_alu(1'b0, '0, '0);
      if (mem_q.size() != 0) set_mem(1'b1, mem_q[0].r, mem_q[0].d);
      else set_mem(1'b0, '0, '0);
      at_sample();
      a_acc = bus.alu_wb_ready;
      m_acc = bus.mem_wb_ready;
      next_cycle();
      if (a_acc && alu_q.size() != 0) void'(alu_q.pop_front());
      if (m_acc && mem_q.size() != 0) void'(mem_q.pop_front());
      budget--;
    end
    set_alu(1'b0, '0, '0);
    set_mem(1'b0, '0, '0);
    check_output("requests_drained", alu_q.size() + mem_q.size(), 0);
    repeat (2) next_cycle();
  endtask

  task automatic check_log(input string name, input bit [AW-1:0] exp [$]);
    check_output({name, "_count"}, wr_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++) begin
      check_output($sformatf("%s_order%0d", name, i), wr_log[i], exp[i]);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [AW-1:0] exp [$];
    set_issue(1'b0, '0, '0, '0);
    set_alu(1'b0, '0, '0);
    set_mem(1'b0, '0, '0);
    #2 rst = 1'b0;
    checking = 1'b1;
    at_sample();
    check_output("reset_we", bus.rf_write_enable, 0);
    check_output("reset_busW", bus.rf_busW, 0);
    check_output("reset_err", bus.wb_err, 0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    $display("[TB] scenario: RAW stall released by ALU writeback");
    set_issue(1'b1, 5'd1, 5'd2, 5'd5);
    at_sample(); check_output("t1_issue_free", bus.issue_ready, 1); next_cycle();
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    at_sample(); check_output("t1_raw_block", bus.issue_ready, 0); next_cycle();
    set_issue(1'b0, '0, '0, '0);
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    at_sample(); check_output("t1_alu_ready", bus.alu_wb_ready, 1); next_cycle();
    set_alu(1'b0, '0, '0);
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    at_sample();
    check_output("t1_we", bus.rf_write_enable, 1);
    check_output("t1_reg", bus.rf_write_reg, 5);
    check_output("t1_busW", bus.rf_busW, 32'hDEADBEEF);
    check_output("t1_still_blocked", bus.issue_ready, 0);
    next_cycle();
    at_sample(); check_output("t1_released", bus.issue_ready, 1); next_cycle();
    set_issue(1'b0, '0, '0, '0);

    $display("[TB] scenario: simultaneous ALU/MEM requests");
    set_issue(1'b1, 5'd0, 5'd0, 5'd3); next_cycle();
    set_issue(1'b1, 5'd0, 5'd0, 5'd4); next_cycle();
    set_issue(1'b0, '0, '0, '0);
    wr_log.delete();
    alu_q.push_back('{5'd3, 32'h3333_0003});
    mem_q.push_back('{5'd4, 32'h4444_0004});
    apply_stimulus();
`ifdef WB_ROUND_ROBIN_EN
    exp = '{5'd3, 5'd4};
`else
    exp = '{5'd4, 5'd3};
`endif
    check_log("t2", exp);

    $display("[TB] scenario: back-to-back conflicts");
    pulse_reset();
    for (int r = 10; r <= 14; r++) begin
      set_issue(1'b1, 5'd0, 5'd0, 5'(r));
      next_cycle();
    end
    set_issue(1'b0, '0, '0, '0);
    wr_log.delete();
    alu_q.push_back('{5'd10, 32'hA0});
    alu_q.push_back('{5'd12, 32'hA2});
    alu_q.push_back('{5'd14, 32'hA4});
    mem_q.push_back('{5'd11, 32'hB1});
    mem_q.push_back('{5'd13, 32'hB3});
    apply_stimulus();
`ifdef WB_ROUND_ROBIN_EN
    exp = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
`else
    exp = '{5'd11, 5'd13, 5'd10, 5'd12, 5'd14};
`endif
    check_log("t3", exp);

    $display("[TB] scenario: register zero");
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    at_sample(); check_output("t4_issue_r0", bus.issue_ready, 1); next_cycle();
    at_sample(); check_output("t4_issue_r0_again", bus.issue_ready, 1); next_cycle();
    set_issue(1'b0, '0, '0, '0);
    set_alu(1'b1, 5'd0, 32'h1);
    at_sample(); check_output("t4_alu_ready", bus.alu_wb_ready, 1); next_cycle();
    set_alu(1'b0, '0, '0);
    at_sample();
    check_output("t4_no_write", bus.rf_write_enable, 0);
    check_output("t4_no_err", bus.wb_err, 0);
    next_cycle();

    $display("[TB] scenario: writeback to unreserved register");
    set_mem(1'b1, 5'd7, 32'h77);
    at_sample(); check_output("t5_mem_ready", bus.mem_wb_ready, 1); next_cycle();
    set_mem(1'b0, '0, '0);
    at_sample();
    check_output("t5_we", bus.rf_write_enable, 1);
    check_output("t5_reg", bus.rf_write_reg, 7);
    check_output("t5_busW", bus.rf_busW, 32'h77);
    check_output("t5_err", bus.wb_err, 1);
    repeat (4) next_cycle();
    at_sample(); check_output("t5_err_sticky", bus.wb_err, 1); next_cycle();

    $display("[TB] scenario: reset during writeback");
    set_issue(1'b1, 5'd0, 5'd0, 5'd9); next_cycle();
    set_issue(1'b0, '0, '0, '0);
    set_alu(1'b1, 5'd9, 32'h99); next_cycle();
    set_alu(1'b0, '0, '0);
    set_issue(1'b1, 5'd9, 5'd0, 5'd0);
    #2;
    check_output("t6_we_before", bus.rf_write_enable, 1);
    check_output("t6_blocked_before", bus.issue_ready, 0);
    rst = 1'b0;
    #1;
    check_output("t6_we_dropped", bus.rf_write_enable, 0);
    check_output("t6_err_cleared", bus.wb_err, 0);
    check_output("t6_issue_ready", bus.issue_ready, 1);
    next_cycle();
    rst = 1'b1;
    set_issue(1'b0, '0, '0, '0);
    repeat (2) next_cycle();

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
